// File: rtl/simplez_core_bus_if.sv
// rtl/simplez_core_bus_if.sv - request/acknowledge memory bus between the Simplez core and the fabric
interface simplez_core_bus_if #(
   parameter int AW = 9,
   parameter int DW = AW + 3
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/simplez_core_bus.sv
// rtl/simplez_core_bus.sv - Simplez ISA core with external req/ack bus, WAIT delay counter and HALT/resume
module simplez_core_bus #(
   parameter int            AW          = 9,
   parameter int            DW          = AW + 3,
   parameter logic [AW-1:0] RESET_PC    = '0,
   parameter int            WAIT_CYCLES = 2400000
) (
   input  logic                 clk,
   input  logic                 rst,
   simplez_core_bus_if.master   bus,
   input  logic                 cont,
   output logic                 halted,
   output logic [DW-1:0]        acc,
   output logic [AW-1:0]        pc,
   output logic                 zflag
);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_MEM    = 3'd2;
   localparam logic [2:0] S_DELAY  = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   localparam logic [2:0] OP_ST  = 3'd0;
   localparam logic [2:0] OP_LD  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_BR  = 3'd3;
   localparam logic [2:0] OP_BZ  = 3'd4;
   localparam logic [2:0] OP_CLR = 3'd5;
   localparam logic [2:0] OP_DEC = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [DW-1:0] ir_q, ir_d;
   logic          zflag_q, zflag_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [2:0]    co;
   logic [AW-1:0] cd;
   logic          bus_active;

   assign co = ir_q[DW-1:DW-3];
   assign cd = ir_q[AW-1:0];
   assign bus_active = (state_q == S_FETCH) || (state_q == S_MEM);

   // Request is gated by rst so an outstanding transfer is abandoned in the same cycle
   assign bus.mem_req   = bus_active && !rst;
   assign bus.mem_we    = (state_q == S_MEM) && (co == OP_ST);
   assign bus.mem_addr  = (state_q == S_MEM) ? cd : pc_q;
   assign bus.mem_wdata = acc_q;

   assign halted = (state_q == S_HALTED);
   assign acc    = acc_q;
   assign pc     = pc_q;
   assign zflag  = zflag_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      ir_d    = ir_q;
      zflag_d = zflag_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               pc_d    = pc_q + AW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            case (co)
               OP_ST, OP_LD, OP_ADD: state_d = S_MEM;
               OP_BR:  pc_d = cd;
               OP_BZ:  if (zflag_q) pc_d = cd;
               OP_CLR: begin
                  acc_d   = '0;
                  zflag_d = 1'b1;
               end
               OP_DEC: begin
                  acc_d   = acc_q - DW'(1);
                  zflag_d = (acc_d == '0);
               end
               default: begin
                  if (ir_q[AW-1]) begin
                     cnt_d   = CW'(WAIT_CYCLES - 1);
                     state_d = S_DELAY;
                  end else begin
                     state_d = S_HALTED;
                  end
               end
            endcase
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               if (co == OP_LD) begin
                  acc_d   = bus.mem_rdata;
                  zflag_d = (acc_d == '0);
               end else if (co == OP_ADD) begin
                  acc_d   = acc_q + bus.mem_rdata;
                  zflag_d = (acc_d == '0);
               end
               state_d = S_FETCH;
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) state_d = S_FETCH;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_HALTED: begin
            if (cont) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         acc_q   <= '0;
         ir_q    <= '0;
         zflag_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         ir_q    <= ir_d;
         zflag_q <= zflag_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_simplez_core_bus.sv
// tb/tb_simplez_core_bus.sv - directed self-checking bench for simplez_core_bus
module tb_simplez_core_bus;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cont = 1'b0;
   logic        halted;
   logic [11:0] acc;
   logic [8:0]  pc;
   logic        zflag;

   int total = 0;
   int bad = 0;

   logic [11:0] mem [0:511];
   int          ws = 0;
   int          wcnt;
   logic        ack_mode = 1'b0;
   logic        ack_man = 1'b0;

   logic        pend;
   logic [8:0]  pa;
   logic        pw;
   logic [11:0] pwd;
   int          stab_err;
   int          cyc;
   int          nrd;
   int          nwr;
   logic [8:0]  rd_addr [0:63];
   int          rd_cyc [0:63];
   logic [8:0]  wr_addr;
   logic [11:0] wr_data;

   simplez_core_bus_if #(.AW(9), .DW(12)) bus ();

   simplez_core_bus #(.AW(9), .DW(12), .RESET_PC(9'd0), .WAIT_CYCLES(5)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cont(cont),
      .halted(halted), .acc(acc), .pc(pc), .zflag(zflag)
   );

   always #5 clk = ~clk;

   assign bus.mem_ack   = ack_mode ? ack_man : (bus.mem_req && (wcnt == ws));
   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0; stab_err <= 0; cyc <= 0; nrd <= 0; nwr <= 0; wcnt <= 0;
      end else begin
         cyc <= cyc + 1;
         if (bus.mem_req) begin
            if (pend && (bus.mem_addr != pa || bus.mem_we != pw || (bus.mem_we && bus.mem_wdata != pwd)))
               stab_err <= stab_err + 1;
            pend <= !bus.mem_ack;
            pa   <= bus.mem_addr;
            pw   <= bus.mem_we;
            pwd  <= bus.mem_wdata;
            if (bus.mem_ack) begin
               wcnt <= 0;
               if (bus.mem_we) begin
                  wr_addr <= bus.mem_addr;
                  wr_data <= bus.mem_wdata;
                  nwr     <= nwr + 1;
               end else if (nrd < 64) begin
                  rd_addr[nrd] <= bus.mem_addr;
                  rd_cyc[nrd]  <= cyc;
                  nrd          <= nrd + 1;
               end
            end else begin
               wcnt <= wcnt + 1;
            end
         end else begin
            pend <= 1'b0;
            wcnt <= 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = 12'h000;
   endtask

   task automatic start(input int w);
      rst = 1'b1;
      ws  = w;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_until_halted(output int n);
      n = 0;
      while (!halted && n < 400) begin
         step();
         n++;
      end
   endtask

   task automatic pulse_cont();
      cont = 1'b1;
      step();
      cont = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
      total++; if (pc !== 9'd0)          begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
      total++; if (acc !== 12'd0)        begin bad++; $display("FAIL reset_acc got=%h exp=0", acc); end
      total++; if (zflag !== 1'b0)       begin bad++; $display("FAIL reset_zflag got=%b exp=0", zflag); end
      total++; if (halted !== 1'b0)      begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
   endtask

   task automatic test_program(input int w);
      int n;
      clear_mem();
      mem[0] = 12'h20A; mem[1] = 12'h40B; mem[2] = 12'h00C; mem[3] = 12'hE00;
      mem[10] = 12'd5;  mem[11] = 12'd7;
      start(w);
      run_until_halted(n);
      total++; if (n !== 11 + 7 * w)    begin bad++; $display("FAIL prog_cycles ws=%0d got=%0d exp=%0d", w, n, 11 + 7 * w); end
      total++; if (nwr !== 1)           begin bad++; $display("FAIL prog_nwr ws=%0d got=%0d exp=1", w, nwr); end
      total++; if (wr_addr !== 9'd12)   begin bad++; $display("FAIL prog_wr_addr ws=%0d got=%0d exp=12", w, wr_addr); end
      total++; if (wr_data !== 12'd12)  begin bad++; $display("FAIL prog_wr_data ws=%0d got=%0d exp=12", w, wr_data); end
      total++; if (pc !== 9'd4)         begin bad++; $display("FAIL prog_pc ws=%0d got=%0d exp=4", w, pc); end
      total++; if (zflag !== 1'b0)      begin bad++; $display("FAIL prog_zflag ws=%0d got=%b exp=0", w, zflag); end
      total++; if (stab_err !== 0)      begin bad++; $display("FAIL prog_bus_stable ws=%0d got=%0d exp=0", w, stab_err); end
      step();
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL halted_no_bus got=%b exp=0", bus.mem_req); end
   endtask

   task automatic test_branch();
      int n;
      clear_mem();
      mem[0] = 12'hA00; mem[1] = 12'h808; mem[8] = 12'h214; mem[9] = 12'h800;
      mem[10] = 12'hE00; mem[20] = 12'd1;
      start(0);
      run_until_halted(n);
      total++; if (n !== 11)            begin bad++; $display("FAIL br_cycles got=%0d exp=11", n); end
      total++; if (nrd !== 6)           begin bad++; $display("FAIL br_nreads got=%0d exp=6", nrd); end
      total++; if (rd_addr[2] !== 9'd8) begin bad++; $display("FAIL bz_taken got=%0d exp=8", rd_addr[2]); end
      total++; if (rd_addr[4] !== 9'd9) begin bad++; $display("FAIL bz_fetch got=%0d exp=9", rd_addr[4]); end
      total++; if (rd_addr[5] !== 9'd10) begin bad++; $display("FAIL bz_not_taken got=%0d exp=10", rd_addr[5]); end
      total++; if (acc !== 12'd1 || zflag !== 1'b0) begin bad++; $display("FAIL br_acc_z got=%h/%b exp=001/0", acc, zflag); end
   endtask

   task automatic test_arith();
      int n;
      clear_mem();
      mem[0] = 12'h20A; mem[1] = 12'h40A; mem[2] = 12'hE00;
      mem[3] = 12'h21E; mem[4] = 12'hC00; mem[5] = 12'hE00;
      mem[6] = 12'hC00; mem[7] = 12'hE00;
      mem[10] = 12'hFFF; mem[30] = 12'd1;
      start(0);
      run_until_halted(n);
      total++; if (n !== 8)              begin bad++; $display("FAIL add_cycles got=%0d exp=8", n); end
      total++; if (acc !== 12'hFFE)      begin bad++; $display("FAIL add_wrap got=%h exp=ffe", acc); end
      total++; if (zflag !== 1'b0)       begin bad++; $display("FAIL add_zflag got=%b exp=0", zflag); end
      total++; if (pc !== 9'd3)          begin bad++; $display("FAIL halt_pc got=%0d exp=3", pc); end
      pulse_cont();
      total++; if (halted !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 9'd3)
         begin bad++; $display("FAIL cont_resume got=%b/%b/%0d exp=0/1/3", halted, bus.mem_req, bus.mem_addr); end
      run_until_halted(n);
      total++; if (n !== 7)              begin bad++; $display("FAIL dec1_cycles got=%0d exp=7", n); end
      total++; if (acc !== 12'd0 || zflag !== 1'b1) begin bad++; $display("FAIL dec_to_zero got=%h/%b exp=000/1", acc, zflag); end
      pulse_cont();
      run_until_halted(n);
      total++; if (acc !== 12'hFFF || zflag !== 1'b0) begin bad++; $display("FAIL dec_wrap got=%h/%b exp=fff/0", acc, zflag); end
      total++; if (pc !== 9'd8)          begin bad++; $display("FAIL dec_pc got=%0d exp=8", pc); end
   endtask

   task automatic test_wait();
      int n;
      clear_mem();
      mem[0] = 12'hF00; mem[1] = 12'hA00; mem[2] = 12'hE00;
      start(0);
      step();
      cont = 1'b1;
      step();
      step();
      cont = 1'b0;
      total++; if (bus.mem_req !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL delay_idle got=%b/%b exp=0/0", bus.mem_req, halted); end
      run_until_halted(n);
      n = n + 3;
      total++; if (n !== 11)             begin bad++; $display("FAIL wait_cycles got=%0d exp=11", n); end
      total++; if (rd_addr[1] !== 9'd1)  begin bad++; $display("FAIL wait_next_addr got=%0d exp=1", rd_addr[1]); end
      total++; if (rd_cyc[1] !== 7)      begin bad++; $display("FAIL wait_fetch_cycle got=%0d exp=7", rd_cyc[1]); end
      total++; if (zflag !== 1'b1 || pc !== 9'd3) begin bad++; $display("FAIL wait_end got=%b/%0d exp=1/3", zflag, pc); end
   endtask

   task automatic test_reset_mid();
      clear_mem();
      mem[0] = 12'h20A; mem[1] = 12'h20B; mem[10] = 12'd5; mem[11] = 12'd9;
      ack_mode = 1'b1;
      ack_man  = 1'b0;
      start(0);
      ack_man = 1'b1; step();
      ack_man = 1'b0; step();
      ack_man = 1'b1; step();
      step();
      ack_man = 1'b0; step();
      step();
      total++; if (acc !== 12'd5)        begin bad++; $display("FAIL mid_acc got=%0d exp=5", acc); end
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 9'd11) begin bad++; $display("FAIL mid_pending got=%b/%0d exp=1/11", bus.mem_req, bus.mem_addr); end
      rst = 1'b1;
      #1;
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req_comb got=%b exp=0", bus.mem_req); end
      ack_man = 1'b1;
      step();
      step();
      total++; if (acc !== 12'd0 || zflag !== 1'b0 || pc !== 9'd0) begin bad++; $display("FAIL rst_late_ack got=%h/%b/%0d exp=000/0/0", acc, zflag, pc); end
      ack_man = 1'b0;
      rst = 1'b0;
      #1;
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 9'd0 || bus.mem_we !== 1'b0)
         begin bad++; $display("FAIL rst_refetch got=%b/%0d/%b exp=1/0/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
      step();
      ack_mode = 1'b0;
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_program(0);
      test_program(3);
      test_branch();
      test_arith();
      test_wait();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
